// File: rtl/modo_de_jogo_ctrl.sv
// Game-mode selector: debounced select/confirm buttons step a 2-bit mode code,
// blink the display while selecting, lock the mode during a game and pulse start.
module modo_de_jogo_ctrl #(
    parameter int NUM_MODES  = 4,
    parameter int DEB_CYCLES = 250000,
    parameter int BLINK_DIV  = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_sel,
    input  logic       btn_conf,
    input  logic       game_over,
    output logic [1:0] mode,
    output logic       display_en,
    output logic       mode_locked,
    output logic       start
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [1:0]    MODE_LAST  = 2'(NUM_MODES - 1);

    typedef enum logic [1:0] {SELECT, PLAYING, GAME_OVER} state_t;

    // Bit 0 carries the select button, bit 1 the confirm button.
    logic [1:0]    btn_raw;
    logic [1:0]    sync1, sync2, db, db_q, ev;
    logic [DW-1:0] cnt [2];

    assign btn_raw = {btn_conf, btn_sel};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            db     <= '0;
            db_q   <= '0;
            ev     <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            db_q  <= db;
            ev    <= db & ~db_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_LAST) begin
                    db[i]  <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DW'(1);
                end
            end
        end
    end

    logic          sel_ev, conf_ev;
    state_t        state, state_nxt;
    logic [1:0]    mode_nxt;
    logic [BW-1:0] bcnt, bcnt_nxt;
    logic          disp_nxt, start_nxt, locked_nxt;

    assign sel_ev  = ev[0];
    assign conf_ev = ev[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SELECT;
            mode        <= 2'd0;
            bcnt        <= '0;
            display_en  <= 1'b1;
            start       <= 1'b0;
            mode_locked <= 1'b0;
        end else begin
            state       <= state_nxt;
            mode        <= mode_nxt;
            bcnt        <= bcnt_nxt;
            display_en  <= disp_nxt;
            start       <= start_nxt;
            mode_locked <= locked_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode;
        bcnt_nxt  = '0;
        disp_nxt  = 1'b1;
        case (state)
            SELECT: begin
                // Confirm takes priority over a same-cycle select.
                if (conf_ev) begin
                    state_nxt = PLAYING;
                end else if (sel_ev) begin
                    mode_nxt = (mode == MODE_LAST) ? 2'd0 : mode + 2'd1;
                end
            end
            PLAYING: begin
                if (game_over) state_nxt = GAME_OVER;
            end
            GAME_OVER: begin
                if (conf_ev) state_nxt = SELECT;
            end
            default: state_nxt = SELECT;
        endcase

        start_nxt  = (state_nxt == PLAYING) && (state != PLAYING);
        locked_nxt = (state_nxt != SELECT);

        // Blink only while staying in SELECT; entering SELECT restarts lit.
        if ((state == SELECT) && (state_nxt == SELECT)) begin
            if (bcnt == BLINK_LAST) begin
                disp_nxt = ~display_en;
                bcnt_nxt = '0;
            end else begin
                disp_nxt = display_en;
                bcnt_nxt = bcnt + BW'(1);
            end
        end
    end

endmodule

// File: doc/modo_de_jogo_ctrl.md
Name: modo_de_jogo_ctrl

Overview:
Sequences game-mode selection for the board. Debounces two pushbuttons (select, confirm), steps a 2-bit mode code through the legal modes, and drives that code to the 7-segment mode decoder (mode[1]→A, mode[0]→B). Blinks the display during selection, locks the mode while a game runs, and gives the game core a one-cycle start pulse.

Parameters:
NUM_MODES, 4, number of legal modes (1..4); mode wraps from NUM_MODES-1 to 0
DEB_CYCLES, 250000, consecutive stable synchronized samples needed to accept a button level change (≥2)
BLINK_DIV, 12500000, clock cycles per display_en toggle while selecting (≥2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous reset, active low
btn_sel  input  1  raw select pushbutton, active high, asynchronous
btn_conf  input  1  raw confirm pushbutton, active high, asynchronous
game_over  input  1  synchronous level from game core, active high
mode  output  2  current mode code to the decoder (mode[1]=A, mode[0]=B)
display_en  output  1  mode display enable (blinks during SELECT)
mode_locked  output  1  high while state is PLAYING or GAME_OVER
start  output  1  one-cycle pulse on entry to PLAYING

Behaviour:
- Reset (rst_n=0, async, any time incl. mid-debounce or mid-game): state=SELECT, mode=0, display_en=1, mode_locked=0, start=0, all synchronizer, debounce, edge and blink registers 0.
- Per button: 2-FF synchronizer → s. Debounce: registers db, cnt. If s==db: cnt<=0. Else if cnt==DEB_CYCLES-1: db<=s, cnt<=0. Else cnt<=cnt+1. A glitch shorter than DEB_CYCLES synchronized cycles never changes db.
- Press event: registered one-cycle pulse, asserted the cycle after db rises 0→1. Release produces no event. Holding the button produces exactly one event.
- Latency: input high first sampled at edge 1 → db=1 at edge 2+DEB_CYCLES → event high after edge 3+DEB_CYCLES → state/mode update at edge 4+DEB_CYCLES.
- States:
  SELECT: sel event → mode <= (mode==NUM_MODES-1) ? 0 : mode+1. conf event → PLAYING. Both events same cycle: conf wins, mode unchanged.
  PLAYING: sel and conf events ignored. game_over=1 → GAME_OVER.
  GAME_OVER: mode held. conf event → SELECT (mode kept, not reset). sel ignored. game_over level ignored.
- start: registered, high exactly in the first cycle state==PLAYING, otherwise 0.
- mode_locked: registered, 1 in PLAYING and GAME_OVER, 0 in SELECT.
- Blink: counter bcnt active only in SELECT. At bcnt==BLINK_DIV-1: display_en toggles, bcnt<=0. On any transition into SELECT: bcnt<=0, display_en<=1. Outside SELECT: display_en=1, bcnt=0.
- mode width fixed 2 bits; values ≥NUM_MODES never produced.
- Events arriving from the debouncer continue to be generated in all states; the FSM decides whether to use them.

Test Plan:
(Params DEB_CYCLES=4, BLINK_DIV=8, NUM_MODES=4 unless noted.)
1. Reset: hold rst_n=0 then release → mode=0, display_en=1, mode_locked=0, start=0; asserting rst_n=0 mid-cycle clears outputs without a clock edge.
2. Debounce: btn_sel high for 3 cycles then low → mode stays 0; btn_sel high and held 20 cycles → mode=1 at 8th edge after first sampled high, stays 1 while held.
3. Wrap: four clean sel presses in SELECT → mode sequence 1,2,3,0; with NUM_MODES=3, three presses → 1,2,0.
4. Confirm/start: from mode=2, conf press → mode_locked=1, start high exactly one cycle, display_en=1 steady; sel presses in PLAYING leave mode=2.
5. Simultaneous: sel and conf rising same cycle in SELECT at mode=1 → PLAYING with mode=1.
6. End-of-game and blink: game_over=1 in PLAYING → GAME_OVER, mode held; conf press → SELECT, mode_locked=0, display_en=1 then toggles every 8 cycles (8 high, 8 low).
